// File: rtl/u_txbuf_of_verifla_pkg.sv
// Shared definitions for the transmit buffer slice.
// Holds the default widths and the sequencer state encoding used by
// u_txbuf_of_verifla. There are no ports; this file only carries definitions.
package u_txbuf_of_verifla_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int AW_DEF     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2
  } seq_state_t;

endpackage

// File: rtl/u_txbuf_of_verifla_fifo.sv
// Circular byte FIFO that feeds the transmit sequencer.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr, data          producer write strobe and byte
//   pop               consume the head entry (ignored when empty)
//   head              entry at the read pointer, read combinationally
//   count             occupancy, 0 .. 2**AW
//   full, empty       decoded from count
//   ovf               sticky flag, set by a write while full
module u_fifo_of_verifla
  import u_txbuf_of_verifla_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              ovf
);

  localparam int          DEPTH    = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_pop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  // A write while full is dropped even if a pop frees a slot that same cycle.
  assign do_wr  = wr && !full;
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr && full) begin
        ovf <= 1'b1;
      end
      unique case ({do_wr, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/u_txbuf_of_verifla.sv
// Transmit buffer: queues producer bytes and hands them one at a time to a
// UART-style transmitter using a held write-enable handshake.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   wr_i, data_i      producer write strobe and byte
//   full_o, empty_o   FIFO status
//   count_o           FIFO occupancy (AW+1 bits)
//   ovf_o             sticky overflow flag
//   tx_data_o         byte presented to the transmitter
//   tx_wen_o          transmitter write enable, held until accepted
//   tx_tre_i          transmitter register empty, 1 = idle
//
// state | meaning
// IDLE  | waiting for a queued byte and an idle transmitter
// LOAD  | byte presented, wen held until the transmitter takes it
// BUSY  | transmitter shifting, waiting for it to go idle again
module u_txbuf_of_verifla
  import u_txbuf_of_verifla_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o,
  output logic              ovf_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_wen_o,
  input  logic              tx_tre_i
);

  seq_state_t        state;
  logic              pop;
  logic [DATA_W-1:0] head;

  u_fifo_of_verifla #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .wr    (wr_i),
    .data  (data_i),
    .pop   (pop),
    .head  (head),
    .count (count_o),
    .full  (full_o),
    .empty (empty_o),
    .ovf   (ovf_o)
  );

  // The pop and the capture into tx_data_o happen on the same edge.
  assign pop = (state == ST_IDLE) && !empty_o && tx_tre_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      tx_wen_o  <= 1'b0;
      tx_data_o <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data_o <= head;
            tx_wen_o  <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // tre falling is the transmitter's acknowledgement of wen.
          if (!tx_tre_i) begin
            tx_wen_o <= 1'b0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (tx_tre_i) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          tx_wen_o <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_u_txbuf_of_verifla.sv
module tb_u_txbuf_of_verifla;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          wr_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          full_o, empty_o, ovf_o, tx_wen_o;
  logic [AW:0]   count_o;
  logic [DW-1:0] tx_data_o;
  logic          tx_tre_i = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  // transmitter control: mode 1 forces tre to tre_force, mode 0 models a UART
  bit tre_mode  = 1'b1;
  bit tre_force = 1'b1;

  u_txbuf_of_verifla #(.DATA_W(DW), .AW(AW)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (wr_i),
    .data_i    (data_i),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .count_o   (count_o),
    .ovf_o     (ovf_o),
    .tx_data_o (tx_data_o),
    .tx_wen_o  (tx_wen_o),
    .tx_tre_i  (tx_tre_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- transmitter model ----------------
  initial begin
    int phase = 0;
    int dly = 0;
    forever begin
      @(posedge clk_i);
      #2;
      if (tre_mode) begin
        tx_tre_i = tre_force;
        phase = 0;
      end else begin
        case (phase)
          0: begin
            tx_tre_i = 1'b1;
            if (tx_wen_o) begin
              dly = $urandom_range(0, 3);
              phase = 1;
            end
          end
          1: begin
            if (dly == 0) begin
              tx_tre_i = 1'b0;
              dly = $urandom_range(1, 6);
              phase = 2;
            end else dly--;
          end
          default: begin
            if (dly == 0) begin
              tx_tre_i = 1'b1;
              phase = 0;
            end else dly--;
          end
        endcase
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [DW-1:0] exp_q[$];
  int            m_cnt = 0;
  bit            m_ovf = 0;
  bit            pend_rst = 1, pend_wr = 0, pend_tre = 1;
  logic [DW-1:0] pend_data = '0;
  bit            prev_wen = 0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk_i) begin
    int cnt0;
    bit popd;
    if (pend_rst) begin
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 0;
      chk("rst_wen", tx_wen_o, 0);
      chk("rst_data", tx_data_o, 0);
    end else begin
      cnt0 = m_cnt;
      popd = tx_wen_o && !prev_wen;
      if (popd) begin
        chk("issue_when_tre_idle", pend_tre, 1);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_issue: got %0h expected no byte", tx_data_o);
        end else begin
          chk("tx_order", tx_data_o, exp_q.pop_front());
          m_cnt--;
        end
      end else begin
        chk("tx_data_stable", tx_data_o, prev_data);
      end
      if (prev_wen) chk("wen_until_accept", tx_wen_o, pend_tre);
      if (pend_wr) begin
        if (cnt0 >= DEPTH) m_ovf = 1;
        else begin
          exp_q.push_back(pend_data);
          m_cnt++;
        end
      end
    end
    chk("count", count_o, m_cnt);
    chk("full", full_o, m_cnt == DEPTH);
    chk("empty", empty_o, m_cnt == 0);
    chk("ovf", ovf_o, m_ovf);
    pend_rst  = rst_i;
    pend_wr   = wr_i;
    pend_data = data_i;
    pend_tre  = tx_tre_i;
    prev_wen  = tx_wen_o;
    prev_data = tx_data_o;
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input int cycles);
    rst_i = 1'b1;
    wr_i  = $urandom_range(0, 1);
    repeat (cycles) tick();
    rst_i = 1'b0;
    wr_i  = 1'b0;
  endtask

  task automatic write_byte(input logic [DW-1:0] d);
    wr_i = 1'b1;
    data_i = d;
    tick();
    wr_i = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((count_o != 0 || tx_wen_o || !tx_tre_i) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_done", n < max_cycles, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int peak;
    int n;
    bit saw;
    // single byte, latency and held enable
    tre_mode = 1; tre_force = 1;
    do_reset(200);
    tick();
    chk("reset_count", count_o, 0);
    chk("reset_empty", empty_o, 1);
    wr_i = 1'b1; data_i = 8'h61;
    tick();
    wr_i = 1'b0;
    chk("lat_not_yet", tx_wen_o, 0);
    tick();
    chk("lat_wen", tx_wen_o, 1);
    chk("lat_data", tx_data_o, 8'h61);
    repeat (50) begin
      tick();
      chk("held_wen", tx_wen_o, 1);
      chk("held_data", tx_data_o, 8'h61);
    end
    tre_force = 0;
    tick();
    tick();
    chk("held_release", tx_wen_o, 0);

    // fill and overflow with transmitter stalled
    do_reset(2);
    wr_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_i = DW'(8'h80 + i);
      tick();
    end
    chk("fill_full", full_o, 1);
    chk("fill_ovf0", ovf_o, 0);
    data_i = 8'hEE;
    tick();
    wr_i = 1'b0;
    chk("fill_count", count_o, 16);
    chk("fill_ovf", ovf_o, 1);
    tre_mode = 0;
    drain(1000);

    // burst
    peak = 0;
    wr_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = DW'(8'h41 + i);
      tick();
      if (int'(count_o) > peak) peak = int'(count_o);
    end
    wr_i = 1'b0;
    chk("burst_peak", peak >= 3, 1);
    drain(500);
    chk("burst_empty", count_o, 0);

    // wrap: 40 bytes streamed with flow control on full
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (full_o && n < 300) begin
        tick();
        n++;
      end
      chk("wrap_wait", n < 300, 1);
      write_byte(DW'(i));
    end
    drain(1000);

    // reset while BUSY with three bytes queued
    do_reset(2);
    tre_mode = 1; tre_force = 1;
    tick();
    wr_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = DW'(8'hA0 + i);
      tick();
    end
    wr_i = 1'b0;
    tre_force = 0;
    tick();
    tick();
    chk("busy_queued", count_o, 3);
    chk("busy_wen", tx_wen_o, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("busy_rst_count", count_o, 0);
    chk("busy_rst_empty", empty_o, 1);
    chk("busy_rst_wen", tx_wen_o, 0);
    tre_force = 1;
    saw = 0;
    repeat (20) begin
      tick();
      if (tx_wen_o) saw = 1;
    end
    chk("no_issue_after_rst", saw, 0);

    // randomized traffic with occasional resets
    tre_mode = 0;
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_i = 1'b1;
        wr_i = $urandom_range(0, 1);
        tick();
        rst_i = 1'b0;
      end
      wr_i = ($urandom_range(0, 99) < 30);
      data_i = DW'($urandom);
      tick();
    end
    wr_i = 1'b0;
    drain(2000);
    repeat (3) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/u_txbuf_of_verifla.md
U_TXBUF_OF_VERIFLA -- requirements
Module: u_txbuf_of_verifla

Interface
REQ-001 Parameter DATA_W, default 8, byte width carried to the transmitter.
REQ-002 Parameter AW, default 4, FIFO address width; depth = 2**AW entries.
REQ-003 One clock; reset is synchronous and active-high; ports clk_i and rst_i.
REQ-004 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 wr_i  input  1  producer write strobe, one byte per cycle while high.
REQ-007 data_i  input  DATA_W  producer byte, sampled when wr_i=1.
REQ-008 full_o  output  1  FIFO holds 2**AW entries.
REQ-009 empty_o  output  1  FIFO holds 0 entries.
REQ-010 count_o  output  AW+1  current occupancy.
REQ-011 ovf_o  output  1  sticky overflow flag.
REQ-012 tx_data_o  output  DATA_W  byte presented to the transmitter data_i.
REQ-013 tx_wen_o  output  1  transmitter write enable (drives transmitter wen_i).
REQ-014 tx_tre_i  input  1  transmitter register empty (from transmitter tre_o); 1 = idle.

Function
REQ-015 FIFO: circular buffer; write pointer and read pointer AW bits each, wrap 2**AW-1 -> 0; count_o is an AW+1-bit counter.
REQ-016 A write with wr_i=1 and full_o=0 stores data_i at the write pointer; the write is visible in count_o on the next cycle.
REQ-017 A write with wr_i=1 and full_o=1 is discarded, sets ovf_o=1, and leaves all FIFO state unchanged; ovf_o clears only on reset.
REQ-018 A simultaneous write and pop in the same cycle leaves count_o unchanged; when full, the write is still discarded, even if a pop occurs that cycle.
REQ-019 full_o and empty_o are decoded combinationally from count_o.
REQ-020 Sequencer FSM states: IDLE, LOAD, BUSY.
REQ-021 IDLE: when empty_o=0 and tx_tre_i=1, pop the head into the tx_data_o register and go to LOAD in one cycle; otherwise stay.
REQ-022 LOAD: tx_wen_o=1; tx_data_o held stable; remain until tx_tre_i=0 (transmitter accepted), then go to BUSY with tx_wen_o=0 on the next cycle.
REQ-023 BUSY: tx_wen_o=0; remain until tx_tre_i=1, then go to IDLE.
REQ-024 tx_wen_o is asserted only in LOAD, so wen stays held across any number of cycles until the transmitter samples it on its baud tick.
REQ-025 Latency: the first byte written into an empty FIFO with an idle transmitter raises tx_wen_o 2 cycles after the wr_i cycle (write, pop/IDLE->LOAD, LOAD).
REQ-026 Back-to-back bytes are issued with no gap other than the BUSY->IDLE->LOAD sequence (2 cycles after tx_tre_i returns high).
REQ-027 tx_data_o changes only on the IDLE->LOAD pop; it is never altered in LOAD or BUSY.
REQ-028 Bytes reach tx_data_o in write order; none is duplicated or dropped, except bytes rejected on overflow.

Reset
REQ-029 With rst_i=1 at a clock edge: pointers=0, count_o=0, empty_o=1, full_o=0, ovf_o=0, FSM=IDLE, tx_wen_o=0, tx_data_o=0.
REQ-030 Reset mid-operation, including in LOAD or BUSY, discards all buffered bytes and deasserts tx_wen_o on the same edge; no byte is issued until a new write occurs after reset.
REQ-031 While rst_i=1, wr_i is ignored.

Structure
REQ-032 A shared package holds the state encoding (IDLE=0, LOAD=1, BUSY=2, 2 bits) and default widths DATA_W=8 and AW=4.
REQ-033 One sub-module, u_fifo_of_verifla, holds the storage, pointers and count; the sequencer FSM lives in the top.
REQ-034 Storage is a register array with no read-during-write bypass; the head is read combinationally from the read pointer.

Verification
REQ-035 Single byte: reset 2 us, write 8'h61 -> tx_wen_o=1 two cycles later with tx_data_o=8'h61; the paired receiver outputs rdy_o with data_o=8'h61.
REQ-036 Burst: write 8'h41..8'h44 on consecutive cycles with the real transmitter, baud generator and receiver -> the receiver delivers 41,42,43,44 in order; count_o peaks at 3 or 4 and returns to 0.
REQ-037 Fill/overflow: with tx_tre_i forced 0, write 17 bytes -> full_o=1 after 16, count_o=16, ovf_o=1, and the 17th byte is never transmitted.
REQ-038 Wrap: 40 bytes 8'h00..8'h27 streamed through the real transmitter loop -> all 40 received in order, exercising pointer wrap twice.
REQ-039 Held enable: tx_tre_i kept 1 for 50 cycles after LOAD -> tx_wen_o stays 1 and tx_data_o stays stable for all 50 cycles; when tx_tre_i drops, the FSM goes to BUSY and tx_wen_o falls.
REQ-040 Reset in BUSY with 3 bytes queued -> next cycle count_o=0, empty_o=1, tx_wen_o=0; no further tx_wen_o pulse occurs without a new write.
